// File: rtl/sfifo_ctrl.sv
// ----------------------------------------------------------------------------
// sfifo_ctrl -- synchronous FIFO controller for an external 1R/1W RAM
//
// The controller sequences a RAM whose read address is registered: read data
// returns one cycle after the address is sampled. It keeps the write/read
// pointers and the RAM occupancy, prefetches RAM reads, and holds a 2-entry
// first-word-fall-through output stage. The stage lets both streams run at
// 1 beat/cycle while still absorbing the one-cycle RAM read latency.
//
// Handshake: a beat moves on an interface at a rising edge where valid and
// ready are both 1. s_ready depends on state only, never on s_valid. m_valid
// depends on state only. Once m_valid is 1 it stays 1, with m_data stable,
// until the beat is popped or the FIFO is flushed.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   flush                synchronous clear of all contents (priority)
//   s_valid/s_ready/s_data   push stream
//   m_valid/m_ready/m_data   pop stream (head of FIFO)
//   ram_wen/ram_wadr/ram_wdata   RAM write port
//   ram_radr/ram_rdata           RAM read port (registered address)
//   ram_level            entries currently held in RAM
//   afull                almost full, registered (only with SFIFO_AFULL_EN)
//
// Optional feature macro: SFIFO_AFULL_EN adds the afull output and the
// SFIFOAFTH parameter.
// ----------------------------------------------------------------------------
module sfifo_ctrl #(
    parameter int SFIFODW = 32,
    parameter int SFIFOAW = 2,
    parameter int SFIFODP = 4
`ifdef SFIFO_AFULL_EN
    ,
    parameter int SFIFOAFTH = 3
`endif
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [SFIFODW-1:0] s_data,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [SFIFODW-1:0] m_data,
    output logic               ram_wen,
    output logic [SFIFOAW-1:0] ram_wadr,
    output logic [SFIFODW-1:0] ram_wdata,
    output logic [SFIFOAW-1:0] ram_radr,
    input  logic [SFIFODW-1:0] ram_rdata,
    output logic [SFIFOAW:0]   ram_level
`ifdef SFIFO_AFULL_EN
    ,
    output logic               afull
`endif
);

    localparam int LVLW = SFIFOAW + 1;
    localparam logic [LVLW-1:0]    LVL_DP  = LVLW'(SFIFODP);
    localparam logic [SFIFOAW-1:0] PTR_MAX = SFIFOAW'(SFIFODP - 1);

    logic [SFIFOAW-1:0] wr_ptr, rd_ptr;
    logic [LVLW-1:0]    lvl_q, lvl_nxt;
    logic               inflight;
    logic [1:0]         stage_cnt, stage_cnt_nxt, cnt_after_pop;
    logic [SFIFODW-1:0] stage0, stage1, stage0_nxt, stage1_nxt;
    logic               push, pop, issue;
    logic [2:0]         pending;

    // Depth need not be a power of two, so wrap explicitly.
    function automatic logic [SFIFOAW-1:0] ptr_inc(input logic [SFIFOAW-1:0] p);
        return (p == PTR_MAX) ? '0 : p + 1'b1;
    endfunction

    assign s_ready   = (lvl_q < LVL_DP);
    assign m_valid   = (stage_cnt != 2'd0);
    assign m_data    = stage0;
    assign ram_level = lvl_q;

    assign push = s_valid & s_ready & ~flush;
    assign pop  = m_valid & m_ready;

    // Stage slots already spoken for after this cycle's pop: held entries plus
    // the read returning at the next edge. Issue only if one slot remains.
    assign pending = {1'b0, stage_cnt} + {2'b00, inflight} - {2'b00, pop};
    assign issue   = (lvl_q != '0) & (pending < 3'd2) & ~flush;

    assign ram_wen   = push;
    assign ram_wadr  = wr_ptr;
    assign ram_wdata = s_data;
    assign ram_radr  = rd_ptr;

    assign lvl_nxt = lvl_q + {{SFIFOAW{1'b0}}, push} - {{SFIFOAW{1'b0}}, issue};

    // Output stage: shift on pop, then land returning RAM data in the lowest
    // free slot. The issue rule guarantees a free slot whenever inflight is set.
    always_comb begin
        cnt_after_pop = stage_cnt - {1'b0, pop};
        stage0_nxt    = stage0;
        stage1_nxt    = stage1;
        if (pop && (stage_cnt == 2'd2)) begin
            stage0_nxt = stage1;
        end
        if (inflight) begin
            if (cnt_after_pop == 2'd0) begin
                stage0_nxt = ram_rdata;
            end else begin
                stage1_nxt = ram_rdata;
            end
        end
        stage_cnt_nxt = cnt_after_pop + {1'b0, inflight};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            lvl_q     <= '0;
            inflight  <= 1'b0;
            stage_cnt <= 2'd0;
            stage0    <= '0;
            stage1    <= '0;
        end else if (flush) begin
            // Data registers keep their contents; with stage_cnt=0 they are
            // don't-care, and an in-flight read is simply not captured.
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            lvl_q     <= '0;
            inflight  <= 1'b0;
            stage_cnt <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (issue) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            lvl_q     <= lvl_nxt;
            inflight  <= issue;
            stage_cnt <= stage_cnt_nxt;
            stage0    <= stage0_nxt;
            stage1    <= stage1_nxt;
        end
    end

`ifdef SFIFO_AFULL_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            afull <= 1'b0;
        end else if (flush) begin
            afull <= 1'b0;
        end else begin
            afull <= (lvl_nxt >= LVLW'(SFIFOAFTH));
        end
    end
`endif

endmodule

// File: tb/tb_sfifo_ctrl.sv
// ----------------------------------------------------------------------------
// tb_sfifo_ctrl -- directed bench for sfifo_ctrl (DW=32, AW=2, DP=4).
// A behavioural RAM with a registered read address sits on the RAM port.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
// ----------------------------------------------------------------------------
module tb_sfifo_ctrl;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic        ram_wen;
  logic [1:0]  ram_wadr;
  logic [31:0] ram_wdata;
  logic [1:0]  ram_radr;
  logic [31:0] ram_rdata;
  logic [2:0]  ram_level;
`ifdef SFIFO_AFULL_EN
  logic        afull;
`endif

  sfifo_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .ram_wen   (ram_wen),
    .ram_wadr  (ram_wadr),
    .ram_wdata (ram_wdata),
    .ram_radr  (ram_radr),
    .ram_rdata (ram_rdata),
    .ram_level (ram_level)
`ifdef SFIFO_AFULL_EN
    ,
    .afull     (afull)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // external RAM model: registered read address
  logic [31:0] mem [4];
  always @(posedge clk) begin
    if (ram_wen) mem[ram_wadr] <= ram_wdata;
    ram_rdata <= mem[ram_radr];
  end

  // scoreboard
  logic [31:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // One cycle: drive at the falling edge, sample, update the model, advance.
  task automatic step(input logic sv, input logic [31:0] sd, input logic mr,
                      input logic fl, output logic acc, output logic popped);
    logic [31:0] e;
    s_valid = sv; s_data = sd; m_ready = mr; flush = fl;
    #1;
    acc = 1'b0; popped = 1'b0;
    if (ram_level == 3'd4) check("sready_at_full", {31'd0, s_ready}, 32'd0);
    if (fl) begin
      exp_q.delete();
    end else begin
      if (s_valid && s_ready) begin
        exp_q.push_back(sd);
        acc = 1'b1;
      end
      if (m_valid && m_ready) begin
        popped = 1'b1;
        if (exp_q.size() == 0) begin
          check("pop_unexpected", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("pop_data", m_data, e);
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // directed vector table
  typedef struct {
    logic        sv;
    logic [31:0] sd;
    logic        mr;
    logic        fl;
    logic        e_sr;
    logic        e_mv;
    logic [31:0] e_md;
    logic [2:0]  e_lvl;
    logic        e_wen;
    logic [1:0]  e_wadr;
    logic [1:0]  e_radr;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic sv, input logic [31:0] sd, input logic mr, input logic fl,
                     input logic e_sr, input logic e_mv, input logic [31:0] e_md,
                     input logic [2:0] e_lvl, input logic e_wen,
                     input logic [1:0] e_wadr, input logic [1:0] e_radr);
    vec_t v;
    v.sv = sv; v.sd = sd; v.mr = mr; v.fl = fl;
    v.e_sr = e_sr; v.e_mv = e_mv; v.e_md = e_md; v.e_lvl = e_lvl;
    v.e_wen = e_wen; v.e_wadr = e_wadr; v.e_radr = e_radr;
    vq.push_back(v);
  endtask

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic acc, pp;
    int   n_acc, n_pop, first_pop, last_pop, cyc;

    rst_n = 1'b0; flush = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_sready", {31'd0, s_ready}, 32'd1);
    check("rst_mvalid", {31'd0, m_valid}, 32'd0);
    check("rst_mdata", m_data, 32'd0);
    check("rst_level", {29'd0, ram_level}, 32'd0);
    check("rst_wen", {31'd0, ram_wen}, 32'd0);
`ifdef SFIFO_AFULL_EN
    check("rst_afull", {31'd0, afull}, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    //   sv  sd            mr fl | sr mv md            lvl wen wadr radr
    // single beat
    add(1, 32'hA5A5A5A5, 0, 0,  1, 0, 32'h0,        0, 1, 0, 0);
    add(0, 32'h0,        0, 0,  1, 0, 32'h0,        1, 0, 1, 0);
    add(0, 32'h0,        0, 0,  1, 0, 32'h0,        0, 0, 1, 1);
    add(0, 32'h0,        1, 0,  1, 1, 32'hA5A5A5A5, 0, 0, 1, 1);
    add(0, 32'h0,        0, 0,  1, 0, 32'h0,        0, 0, 1, 1);
    // fill with 1..7, only 6 fit
    add(1, 32'd1,        0, 0,  1, 0, 32'h0,        0, 1, 1, 1);
    add(1, 32'd2,        0, 0,  1, 0, 32'h0,        1, 1, 2, 1);
    add(1, 32'd3,        0, 0,  1, 0, 32'h0,        1, 1, 3, 2);
    add(1, 32'd4,        0, 0,  1, 1, 32'd1,        1, 1, 0, 3);
    add(1, 32'd5,        0, 0,  1, 1, 32'd1,        2, 1, 1, 3);
    add(1, 32'd6,        0, 0,  1, 1, 32'd1,        3, 1, 2, 3);
    add(1, 32'd7,        0, 0,  0, 1, 32'd1,        4, 0, 3, 3);
    // pop with full RAM: s_ready stays 0 this cycle
    add(1, 32'h77,       1, 0,  0, 1, 32'd1,        4, 0, 3, 3);
    add(0, 32'h0,        1, 0,  1, 1, 32'd2,        3, 0, 3, 0);
    add(0, 32'h0,        1, 0,  1, 1, 32'd3,        2, 0, 3, 1);
    add(0, 32'h0,        1, 0,  1, 1, 32'd4,        1, 0, 3, 2);
    add(0, 32'h0,        1, 0,  1, 1, 32'd5,        0, 0, 3, 3);
    add(0, 32'h0,        1, 0,  1, 1, 32'd6,        0, 0, 3, 3);
    add(0, 32'h0,        0, 0,  1, 0, 32'h0,        0, 0, 3, 3);
    // partial fill, then flush with a push in the same cycle
    add(1, 32'h10,       0, 0,  1, 0, 32'h0,        0, 1, 3, 3);
    add(1, 32'h11,       0, 0,  1, 0, 32'h0,        1, 1, 0, 3);
    add(1, 32'h12,       0, 0,  1, 0, 32'h0,        1, 1, 1, 0);
    add(1, 32'h13,       0, 0,  1, 1, 32'h10,       1, 1, 2, 1);
    add(1, 32'h14,       0, 0,  1, 1, 32'h10,       2, 1, 3, 1);
    add(1, 32'hEE,       0, 1,  1, 1, 32'h10,       3, 0, 0, 1);
    add(1, 32'h55,       0, 0,  1, 0, 32'h0,        0, 1, 0, 0);
    add(0, 32'h0,        0, 0,  1, 0, 32'h0,        1, 0, 1, 0);
    add(0, 32'h0,        0, 0,  1, 0, 32'h0,        0, 0, 1, 1);
    add(0, 32'h0,        1, 0,  1, 1, 32'h55,       0, 0, 1, 1);
    add(0, 32'h0,        0, 0,  1, 0, 32'h0,        0, 0, 1, 1);

    foreach (vq[i]) begin
      s_valid = vq[i].sv; s_data = vq[i].sd; m_ready = vq[i].mr; flush = vq[i].fl;
      #1;
      check($sformatf("r%0d_sready", i), {31'd0, s_ready}, {31'd0, vq[i].e_sr});
      check($sformatf("r%0d_mvalid", i), {31'd0, m_valid}, {31'd0, vq[i].e_mv});
      check($sformatf("r%0d_level", i), {29'd0, ram_level}, {29'd0, vq[i].e_lvl});
      check($sformatf("r%0d_wen", i), {31'd0, ram_wen}, {31'd0, vq[i].e_wen});
      check($sformatf("r%0d_wadr", i), {30'd0, ram_wadr}, {30'd0, vq[i].e_wadr});
      check($sformatf("r%0d_radr", i), {30'd0, ram_radr}, {30'd0, vq[i].e_radr});
      if (vq[i].e_mv) check($sformatf("r%0d_mdata", i), m_data, vq[i].e_md);
      @(posedge clk);
      @(negedge clk);
    end

    // streaming: 20 beats, push and pop every cycle
    step(0, 0, 0, 1, acc, pp);
    n_pop = 0; n_acc = 0; first_pop = -1; last_pop = -1;
    for (int c = 0; c < 30; c++) begin
      step(n_acc < 20, 32'd100 + n_acc, 1, 0, acc, pp);
      if (acc) n_acc++;
      if (pp) begin
        if (first_pop < 0) first_pop = c;
        last_pop = c;
        n_pop++;
      end
    end
    check("stream_pops", n_pop, 32'd20);
    check("stream_first", first_pop, 32'd3);
    check("stream_span", last_pop - first_pop, 32'd19);
    check("stream_wadr", {30'd0, ram_wadr}, 32'd0);
    check("stream_radr", {30'd0, ram_radr}, 32'd0);

    // random backpressure, 100 beats
    n_acc = 0; n_pop = 0; cyc = 0;
    while (n_pop < 100 && cyc < 3000) begin
      step(n_acc < 100, $urandom, 1'($urandom_range(0, 1)), 0, acc, pp);
      if (acc) n_acc++;
      if (pp) n_pop++;
      cyc++;
    end
    check("bp_pops", n_pop, 32'd100);
    check("bp_queue_left", exp_q.size(), 32'd0);

    // full FIFO, then flush with a push in the same cycle
    n_acc = 0;
    for (int i = 0; i < 8; i++) begin
      step(1, 32'd200 + i, 0, 0, acc, pp);
      if (acc) n_acc++;
    end
    check("full_accepted", n_acc, 32'd6);
    check("full_level", {29'd0, ram_level}, 32'd4);
    check("full_sready", {31'd0, s_ready}, 32'd0);
    step(1, 32'hDEAD, 0, 1, acc, pp);
    check("flush_mvalid", {31'd0, m_valid}, 32'd0);
    check("flush_level", {29'd0, ram_level}, 32'd0);
    check("flush_sready", {31'd0, s_ready}, 32'd1);
    step(1, 32'h55, 0, 0, acc, pp);
    n_pop = 0;
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 1, 0, acc, pp);
      if (pp) n_pop++;
    end
    check("flush_after_pops", n_pop, 32'd1);

    // flush while a RAM read is in flight
    step(1, 32'h66, 0, 0, acc, pp);
    step(0, 0, 0, 0, acc, pp);
    step(0, 0, 0, 1, acc, pp);
    for (int i = 0; i < 3; i++) begin
      check("inflight_drop_mvalid", {31'd0, m_valid}, 32'd0);
      step(0, 0, 1, 0, acc, pp);
    end
    check("inflight_drop_level", {29'd0, ram_level}, 32'd0);

`ifdef SFIFO_AFULL_EN
    // almost-full threshold 3
    for (int i = 0; i < 5; i++) begin
      check("afull_low", {31'd0, afull}, 32'd0);
      step(1, 32'd300 + i, 0, 0, acc, pp);
    end
    check("afull_level3", {29'd0, ram_level}, 32'd3);
    check("afull_high", {31'd0, afull}, 32'd1);
    step(0, 0, 1, 0, acc, pp);
    check("afull_level2", {29'd0, ram_level}, 32'd2);
    check("afull_clear", {31'd0, afull}, 32'd0);
    step(0, 0, 0, 1, acc, pp);
`endif

    // asynchronous reset in the middle of a cycle
    step(1, 32'h77, 0, 0, acc, pp);
    step(1, 32'h78, 0, 0, acc, pp);
    step(0, 0, 0, 0, acc, pp);
    s_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_level", {29'd0, ram_level}, 32'd0);
    check("arst_mvalid", {31'd0, m_valid}, 32'd0);
    check("arst_mdata", m_data, 32'd0);
    check("arst_sready", {31'd0, s_ready}, 32'd1);
    check("arst_radr", {30'd0, ram_radr}, 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
